// File: rtl/onewire_master.sv
// Avalon-MM 1-Wire bus master: reset/presence, byte write and byte read slots in hardware.
// Define ONEWIRE_IRQ_EN to build the ins_irq output and the STATUS irq_en bit.
module onewire_master #(
  parameter int TICKS_PER_US = 50
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic        chipselect,
  input  logic [2:0]  avs_s1_address,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic [31:0] avs_s1_readdata,
  inout  wire         coe_bit
`ifdef ONEWIRE_IRQ_EN
  ,
  output logic        ins_irq
`endif
);

  localparam int PW = (TICKS_PER_US > 2) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_US - 1);
  localparam logic [9:0] RST_LOW_US  = 10'd480;
  localparam logic [9:0] RST_WAIT_US = 10'd70;
  localparam logic [9:0] RST_REC_US  = 10'd410;
  localparam logic [9:0] SLOT_US     = 10'd70;
  localparam logic [9:0] LOW1_US     = 10'd6;
  localparam logic [9:0] LOW0_US     = 10'd60;
  localparam logic [9:0] SAMPLE_US   = 10'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_RST_REC, S_SLOT_LOW, S_SLOT_REL, S_BIT_NEXT
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [9:0]  us_q;
  logic [2:0]  idx_q;
  logic        op_rd_q;
  logic [7:0]  shreg_q, data_q;
  logic        presence_q, done_q, drive_q, drive_d;
  logic [1:0]  sync_q;
  logic [31:0] rdata_q, rdata_d;

  logic wr_cmd, wr_stat, cmd_go, us_tick, enter, line_s, busy, irq_en_bit;
  logic done_set, sample_pres, sample_bit, load_data;
  logic [9:0] low_us, rel_us;

  logic unused_wd;
  assign unused_wd = ^{avs_s1_writedata[31:16], avs_s1_writedata[7:3]};

  assign wr_cmd  = chipselect && avs_s1_write && (avs_s1_address == 3'd0);
  assign wr_stat = chipselect && avs_s1_write && (avs_s1_address == 3'd1);
  assign cmd_go  = wr_cmd && (state_q == S_IDLE) && (avs_s1_writedata[1:0] != 2'd3);
  assign us_tick = (presc_q == PRESC_MAX);
  assign enter   = (state_d != state_q);
  assign line_s  = sync_q[1];
  // Reads always use the short low pulse; writes pick by the current data bit.
  assign low_us  = (op_rd_q || shreg_q[idx_q]) ? LOW1_US : LOW0_US;
  assign rel_us  = SLOT_US - low_us;

  assign coe_bit = drive_q ? 1'b0 : 1'bz;
  assign avs_s1_readdata = rdata_q;

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    done_set    = 1'b0;
    sample_pres = 1'b0;
    sample_bit  = 1'b0;
    load_data   = 1'b0;
    case (state_q)
      S_IDLE:
        if (cmd_go) state_d = (avs_s1_writedata[1:0] == 2'd0) ? S_RST_LOW : S_SLOT_LOW;
      S_RST_LOW:
        if (us_tick && us_q == RST_LOW_US - 10'd1) state_d = S_RST_WAIT;
      S_RST_WAIT:
        if (us_tick && us_q == RST_WAIT_US - 10'd1) begin
          state_d     = S_RST_REC;
          sample_pres = 1'b1;
        end
      S_RST_REC:
        if (us_tick && us_q == RST_REC_US - 10'd1) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      S_SLOT_LOW:
        if (us_tick && us_q == low_us - 10'd1) state_d = S_SLOT_REL;
      S_SLOT_REL: begin
        // us_q restarts at release, so the 15 us slot point is offset by the low time.
        if (op_rd_q && us_tick && us_q == SAMPLE_US - LOW1_US - 10'd1) sample_bit = 1'b1;
        if (us_tick && us_q == rel_us - 10'd1) state_d = S_BIT_NEXT;
      end
      S_BIT_NEXT:
        if (idx_q == 3'd7) begin
          state_d   = S_IDLE;
          done_set  = 1'b1;
          load_data = op_rd_q;
        end else begin
          state_d = S_SLOT_LOW;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drive_d = (state_d == S_RST_LOW) || (state_d == S_SLOT_LOW);
    busy    = (state_q != S_IDLE);
    rdata_d = '0;
    case (avs_s1_address)
      3'd1:    rdata_d = {28'd0, irq_en_bit, done_q, presence_q, busy};
      3'd2:    rdata_d = {24'd0, data_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      presc_q    <= '0;
      us_q       <= '0;
      idx_q      <= '0;
      op_rd_q    <= 1'b0;
      shreg_q    <= '0;
      data_q     <= '0;
      presence_q <= 1'b0;
      done_q     <= 1'b0;
      drive_q    <= 1'b0;
      sync_q     <= 2'b11;
      rdata_q    <= '0;
    end else begin
      if (enter || us_tick || state_q == S_IDLE) presc_q <= '0;
      else                                       presc_q <= presc_q + 1'b1;
      if (enter || state_q == S_IDLE) us_q <= '0;
      else if (us_tick)               us_q <= us_q + 10'd1;
      if (cmd_go) begin
        op_rd_q <= (avs_s1_writedata[1:0] == 2'd2);
        shreg_q <= avs_s1_writedata[15:8];
        idx_q   <= '0;
      end else begin
        if (state_q == S_BIT_NEXT && idx_q != 3'd7) idx_q <= idx_q + 3'd1;
        if (sample_bit) shreg_q[idx_q] <= line_s;
      end
      if (load_data)   data_q     <= shreg_q;
      if (sample_pres) presence_q <= ~line_s;
      // A completion in the same cycle as a clear-done write keeps done set.
      done_q  <= done_set | (done_q & ~(wr_stat & avs_s1_writedata[2]));
      drive_q <= drive_d;
      sync_q  <= {sync_q[0], coe_bit};
      rdata_q <= rdata_d;
    end
  end

`ifdef ONEWIRE_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_stat) irq_en_q <= avs_s1_writedata[3];
      irq_q <= done_q & irq_en_q;
    end
  end
  assign irq_en_bit = irq_en_q;
  assign ins_irq    = irq_q;
`else
  assign irq_en_bit = 1'b0;
`endif

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at TICKS_PER_US=2 with a pulled-up line and a device model.
module tb_onewire_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  wire         line;
  logic        dev_low = 1'b0;
`ifdef ONEWIRE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  assign line = dev_low ? 1'b0 : 1'bz;
  pullup (line);

  onewire_master #(.TICKS_PER_US(2)) dut (
    .csi_clk(clk),
    .csi_reset(rst),
    .chipselect(cs),
    .avs_s1_address(addr),
    .avs_s1_write(wr),
    .avs_s1_writedata(wdata),
    .avs_s1_readdata(rdata),
    .coe_bit(line)
`ifdef ONEWIRE_IRQ_EN
    , .ins_irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Device model: mode 1 answers a reset with a presence pulse, mode 2 returns model_byte.
  int         model_mode = 0;
  logic [7:0] model_byte = 8'h00;
  int         m_idx = 0, m_wait = 0, m_hold = 0;
  logic       line_prev = 1'b1, pres_armed = 1'b0;

  always @(posedge clk) begin
    if (model_mode == 0) begin
      m_idx      <= 0;
      pres_armed <= 1'b1;
    end
    if (m_hold > 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1) dev_low <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        dev_low <= 1'b1;
        m_hold  <= 240;
      end
    end else if (model_mode == 1 && pres_armed && line_prev == 1'b0 && line == 1'b1) begin
      m_wait     <= 60;
      pres_armed <= 1'b0;
    end else if (model_mode == 2 && line_prev == 1'b1 && line == 1'b0 && m_idx < 8) begin
      if (!model_byte[m_idx]) begin
        dev_low <= 1'b1;
        m_hold  <= 60;
      end
      m_idx <= m_idx + 1;
    end
    line_prev <= line;
  end

  logic line_log [0:1199];
  int   nfall;
  int   fall_at [0:15];
  int   wid [0:15];

  task automatic avs_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      line_log[i] = line;
      @(negedge clk);
    end
  endtask

  task automatic measure_slots(input int n);
    nfall = 0;
    for (int i = 0; i < n; i++) begin
      if (line_log[i] == 1'b0 && (i == 0 || line_log[i-1] == 1'b1)) begin
        if (nfall < 16) begin
          fall_at[nfall] = i;
          wid[nfall] = 0;
          for (int j = i; j < n && line_log[j] == 1'b0; j++) wid[nfall]++;
        end
        nfall++;
      end
    end
  endtask

  task automatic set_model(input int mode, input logic [7:0] b);
    model_mode = 0;
    @(negedge clk);
    model_byte = b;
    model_mode = mode;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    checks++; if (line !== 1'b1) begin errors++; $display("FAIL reset_line: got %b want 1", line); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
`ifdef ONEWIRE_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    rst = 1'b0;
    @(negedge clk);
    avs_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status: got %0h want 0", d); end
    avs_read(3'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", d); end
  endtask

  task automatic test_status();
    logic [31:0] d;
    logic [31:0] exp_en;
`ifdef ONEWIRE_IRQ_EN
    exp_en = 32'h8;
`else
    exp_en = 32'h0;
`endif
    avs_write(3'd1, 32'h8);
    avs_read(3'd1, d);
    checks++; if (d !== exp_en) begin errors++; $display("FAIL status_irq_en: got %0h want %0h", d, exp_en); end
    avs_write(3'd1, 32'h0);
    avs_write(3'd0, 32'h3);
    avs_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL noop_status: got %0h want 0", d); end
    checks++; if (line !== 1'b1) begin errors++; $display("FAIL noop_line: got %b want 1", line); end
    avs_read(3'd7, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL bad_addr: got %0h want 0", d); end
  endtask

  task automatic run_reset_op(input string tag, input logic [31:0] exp_mid, input logic [31:0] exp_end);
    int low = 0;
    logic seen_high = 1'b0;
    logic [31:0] st_a = '0, st_b = '0;
    avs_write(3'd0, 32'h0);
    addr = 3'd1;
    for (int k = 1; k <= 1922; k++) begin
      if (!seen_high) begin
        if (line == 1'b0) low++;
        else seen_high = 1'b1;
      end
      if (k == 1918) st_a = rdata;
      if (k == 1922) st_b = rdata;
      if (k < 1922) @(negedge clk);
    end
    checks++; if (low !== 960) begin errors++; $display("FAIL %s_low_width: got %0d want 960", tag, low); end
    checks++; if (st_a !== exp_mid) begin errors++; $display("FAIL %s_status_busy: got %0h want %0h", tag, st_a, exp_mid); end
    checks++; if (st_b !== exp_end) begin errors++; $display("FAIL %s_status_end: got %0h want %0h", tag, st_b, exp_end); end
  endtask

  task automatic test_presence();
    set_model(1, 8'h00);
    run_reset_op("presence", 32'h3, 32'h6);
  endtask

  task automatic test_no_device();
    logic [31:0] d;
    logic [31:0] st_a = '0;
    set_model(0, 8'h00);
    avs_write(3'd1, 32'h4);
    avs_write(3'd0, 32'h0);
    addr = 3'd1;
    for (int k = 1; k < 1920; k++) begin
      if (k == 1500) st_a = rdata;
      @(negedge clk);
    end
    // Clear-done write lands on the same edge as the completion.
    avs_write(3'd1, 32'h4);
    avs_read(3'd1, d);
    checks++; if (st_a !== 32'h1) begin errors++; $display("FAIL nodev_busy: got %0h want 1", st_a); end
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL nodev_set_wins: got %0h want 4", d); end
    avs_write(3'd1, 32'h4);
    avs_read(3'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL nodev_clear: got %0h want 0", d); end
  endtask

  task automatic test_write();
    logic [31:0] d;
    logic [7:0] eb = 8'hA5;
    avs_write(3'd0, 32'h0000_A501);
    capture(1140);
    measure_slots(1140);
    checks++; if (nfall !== 8) begin errors++; $display("FAIL write_slots: got %0d want 8", nfall); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wid[k] !== (eb[k] ? 12 : 120)) begin
        errors++; $display("FAIL write_low[%0d]: got %0d want %0d", k, wid[k], eb[k] ? 12 : 120);
      end
      if (k > 0) begin
        checks++;
        if (fall_at[k] - fall_at[k-1] !== 141) begin
          errors++; $display("FAIL write_period[%0d]: got %0d want 141", k, fall_at[k] - fall_at[k-1]);
        end
      end
    end
    avs_read(3'd1, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL write_done: got %0h want 4", d); end
    avs_read(3'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL write_data: got %0h want 0", d); end
    avs_write(3'd1, 32'h4);
  endtask

  task automatic test_read();
    logic [31:0] d;
    set_model(2, 8'h3C);
    avs_write(3'd0, 32'h2);
    repeat (1140) @(negedge clk);
    avs_read(3'd1, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL read_done: got %0h want 4", d); end
    avs_read(3'd2, d);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL read_data: got %0h want 3c", d); end
    set_model(0, 8'h00);
    avs_write(3'd1, 32'h4);
  endtask

  task automatic test_ignored();
    logic [7:0] eb = 8'hA5;
    avs_write(3'd0, 32'h0000_A501);
    fork
      capture(1140);
      begin
        repeat (2) @(negedge clk);
        avs_write(3'd0, 32'h0000_0001);
      end
    join
    measure_slots(1140);
    checks++; if (nfall !== 8) begin errors++; $display("FAIL busy_cmd_slots: got %0d want 8", nfall); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wid[k] !== (eb[k] ? 12 : 120)) begin
        errors++; $display("FAIL busy_cmd_low[%0d]: got %0d want %0d", k, wid[k], eb[k] ? 12 : 120);
      end
    end
    avs_write(3'd1, 32'h4);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    avs_write(3'd0, 32'h0000_0001);
    repeat (5) @(negedge clk);
    checks++; if (line !== 1'b0) begin errors++; $display("FAIL midslot_low: got %b want 0", line); end
    rst = 1'b1;
    #1;
    checks++; if (line !== 1'b1) begin errors++; $display("FAIL rst_release: got %b want 1", line); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    avs_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_status: got %0h want 0", d); end
    avs_read(3'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_data: got %0h want 0", d); end
    set_model(1, 8'h00);
    run_reset_op("after_rst", 32'h3, 32'h6);
    set_model(0, 8'h00);
  endtask

`ifdef ONEWIRE_IRQ_EN
  task automatic test_irq();
    avs_write(3'd1, 32'hC);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    avs_write(3'd0, 32'h0);
    repeat (1925) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
    avs_write(3'd1, 32'hC);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_status();
    test_presence();
    test_no_device();
    test_write();
    test_read();
    test_ignored();
    test_async_reset();
`ifdef ONEWIRE_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
